// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, req/ack imem reads, valid/ready IF/ID slot
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int              PC_INC   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pcsrc,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc_next,
    input  logic               ifid_ready
);

    typedef enum logic {FETCH, HOLD} state_t;

    localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    fetch_addr_q, fetch_addr_d;
    logic               imem_req_q, imem_req_d;
    logic               drop_q, drop_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [PC_W-1:0]    hold_pc_next_q, hold_pc_next_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc_next_q, ifid_pc_next_d;

    logic               slot_free;
    logic               ack_v;
    logic [PC_W-1:0]    fetch_next;
    logic [PC_W-1:0]    target_aligned;

    assign slot_free      = !ifid_valid_q || ifid_ready;
    // An ack only counts while a request is actually on the bus.
    assign ack_v          = imem_req_q && imem_ack;
    assign fetch_next     = fetch_addr_q + INC;
    assign target_aligned = {branch_target[PC_W-1:1], 1'b0};

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        fetch_addr_d   = fetch_addr_q;
        imem_req_d     = imem_req_q;
        drop_d         = drop_q;
        hold_instr_d   = hold_instr_q;
        hold_pc_next_d = hold_pc_next_q;
        ifid_valid_d   = ifid_valid_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_next_d = ifid_pc_next_q;

        if (ifid_valid_q && ifid_ready) begin
            ifid_valid_d = 1'b0;
        end

        if (pcsrc) begin
            pc_d         = target_aligned;
            ifid_valid_d = 1'b0;
            state_d      = FETCH;
            imem_req_d   = 1'b1;
            // A request still waiting for its ack must keep its address; mark it for discard.
            if (state_q == HOLD || ack_v || !imem_req_q) begin
                fetch_addr_d = target_aligned;
                drop_d       = 1'b0;
            end else begin
                drop_d = 1'b1;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    imem_req_d = 1'b1;
                    if (ack_v) begin
                        if (drop_q) begin
                            drop_d       = 1'b0;
                            fetch_addr_d = pc_q;
                        end else if (slot_free && !stall) begin
                            ifid_valid_d   = 1'b1;
                            ifid_instr_d   = imem_rdata;
                            ifid_pc_next_d = fetch_next;
                            pc_d           = fetch_next;
                            fetch_addr_d   = fetch_next;
                        end else begin
                            hold_instr_d   = imem_rdata;
                            hold_pc_next_d = fetch_next;
                            state_d        = HOLD;
                            imem_req_d     = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    imem_req_d = 1'b0;
                    if (slot_free && !stall) begin
                        ifid_valid_d   = 1'b1;
                        ifid_instr_d   = hold_instr_q;
                        ifid_pc_next_d = hold_pc_next_q;
                        pc_d           = hold_pc_next_q;
                        fetch_addr_d   = hold_pc_next_q;
                        state_d        = FETCH;
                        imem_req_d     = 1'b1;
                    end
                end
                default: begin
                    state_d    = FETCH;
                    imem_req_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            fetch_addr_q   <= RESET_PC;
            imem_req_q     <= 1'b0;
            drop_q         <= 1'b0;
            hold_instr_q   <= '0;
            hold_pc_next_q <= '0;
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= '0;
            ifid_pc_next_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_addr_q   <= fetch_addr_d;
            imem_req_q     <= imem_req_d;
            drop_q         <= drop_d;
            hold_instr_q   <= hold_instr_d;
            hold_pc_next_q <= hold_pc_next_d;
            ifid_valid_q   <= ifid_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_next_q <= ifid_pc_next_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = fetch_addr_q;
    assign ifid_valid   = ifid_valid_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_pc_next = ifid_pc_next_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        pcsrc;
    logic [15:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_next;
    logic        ifid_ready;

    int checks;
    int errors;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcsrc        (pcsrc),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc_next (ifid_pc_next),
        .ifid_ready   (ifid_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 16'h0000 ||
            ifid_instr !== 16'h0000 || ifid_pc_next !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state req=%b valid=%b addr=%h instr=%h pcn=%h required 0 0 0000 0000 0000",
                     imem_req, ifid_valid, imem_addr, ifid_instr, ifid_pc_next);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release req=%b addr=%h valid=%b required 1 0000 0", imem_req, imem_addr, ifid_valid);
        end
    endtask

    task automatic test_stream();
        logic [15:0] data [3];
        logic [15:0] pcn  [3];
        data[0] = 16'h1111; data[1] = 16'h2222; data[2] = 16'h3333;
        pcn[0]  = 16'h0002; pcn[1]  = 16'h0004; pcn[2]  = 16'h0006;
        ifid_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = data[i];
            step();
            checks++;
            if (ifid_valid !== 1'b1 || ifid_instr !== data[i] || ifid_pc_next !== pcn[i] ||
                imem_addr !== pcn[i] || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d valid=%b instr=%h pcn=%h addr=%h req=%b required 1 %h %h %h 1",
                         i, ifid_valid, ifid_instr, ifid_pc_next, imem_addr, imem_req, data[i], pcn[i], pcn[i]);
            end
        end
        imem_ack = 1'b0;
        step();
        checks++;
        if (ifid_valid !== 1'b0 || imem_addr !== 16'h0006) begin
            errors++;
            $display("FAIL stream_drain valid=%b addr=%h required 0 0006", ifid_valid, imem_addr);
        end
    endtask

    task automatic test_hold();
        ifid_ready = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'hAAAA;
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 16'hAAAA || ifid_pc_next !== 16'h0008) begin
            errors++;
            $display("FAIL hold_fill valid=%b instr=%h pcn=%h required 1 AAAA 0008", ifid_valid, ifid_instr, ifid_pc_next);
        end
        imem_rdata = 16'h4444;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || ifid_instr !== 16'hAAAA || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_enter req=%b instr=%h valid=%b required 0 AAAA 1", imem_req, ifid_instr, ifid_valid);
        end
        step();
        checks++;
        if (imem_req !== 1'b0 || dut.state_q !== 1'b1) begin
            errors++;
            $display("FAIL hold_stay req=%b state=%b required 0 1", imem_req, dut.state_q);
        end
        ifid_ready = 1'b1;
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 16'h4444 || ifid_pc_next !== 16'h000A ||
            imem_req !== 1'b1 || imem_addr !== 16'h000A) begin
            errors++;
            $display("FAIL hold_release valid=%b instr=%h pcn=%h req=%b addr=%h required 1 4444 000A 1 000A",
                     ifid_valid, ifid_instr, ifid_pc_next, imem_req, imem_addr);
        end
        step();
    endtask

    task automatic test_redirect();
        pcsrc         = 1'b1;
        branch_target = 16'h0031;
        step();
        pcsrc = 1'b0;
        checks++;
        if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h000A) begin
            errors++;
            $display("FAIL redirect_pending valid=%b req=%b addr=%h required 0 1 000A", ifid_valid, imem_req, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        step();
        checks++;
        if (ifid_valid !== 1'b0 || imem_addr !== 16'h0030 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL redirect_drop valid=%b addr=%h req=%b required 0 0030 1", ifid_valid, imem_addr, imem_req);
        end
        imem_rdata = 16'hBEEF;
        step();
        imem_ack = 1'b0;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 16'hBEEF || ifid_pc_next !== 16'h0032) begin
            errors++;
            $display("FAIL redirect_target valid=%b instr=%h pcn=%h required 1 BEEF 0032", ifid_valid, ifid_instr, ifid_pc_next);
        end
        step();
    endtask

    task automatic test_wrap();
        pcsrc         = 1'b1;
        branch_target = 16'hFFFF;
        imem_ack      = 1'b1;
        imem_rdata    = 16'h1234;
        step();
        pcsrc = 1'b0;
        checks++;
        if (ifid_valid !== 1'b0 || imem_addr !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_redirect valid=%b addr=%h required 0 FFFE", ifid_valid, imem_addr);
        end
        imem_rdata = 16'h5555;
        step();
        imem_ack = 1'b0;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 16'h5555 || ifid_pc_next !== 16'h0000 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap valid=%b instr=%h pcn=%h addr=%h required 1 5555 0000 0000",
                     ifid_valid, ifid_instr, ifid_pc_next, imem_addr);
        end
        step();
    endtask

    task automatic test_stall_flush();
        ifid_ready = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h7777;
        step();
        stall      = 1'b1;
        imem_rdata = 16'h6666;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_instr !== 16'h7777 || ifid_pc_next !== 16'h0002) begin
            errors++;
            $display("FAIL stall_enter req=%b valid=%b instr=%h pcn=%h required 0 1 7777 0002",
                     imem_req, ifid_valid, ifid_instr, ifid_pc_next);
        end
        step();
        checks++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_instr !== 16'h7777) begin
            errors++;
            $display("FAIL stall_frozen req=%b valid=%b instr=%h required 0 1 7777", imem_req, ifid_valid, ifid_instr);
        end
        pcsrc         = 1'b1;
        branch_target = 16'h0100;
        step();
        pcsrc = 1'b0;
        stall = 1'b0;
        checks++;
        if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL stall_flush valid=%b req=%b addr=%h required 0 1 0100", ifid_valid, imem_req, imem_addr);
        end
        ifid_ready = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h8888;
        step();
        imem_ack = 1'b0;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 16'h8888 || ifid_pc_next !== 16'h0102) begin
            errors++;
            $display("FAIL stall_restart valid=%b instr=%h pcn=%h required 1 8888 0102", ifid_valid, ifid_instr, ifid_pc_next);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        pcsrc         = 1'b0;
        branch_target = 16'h0000;
        stall         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0000;
        ifid_ready    = 1'b1;
        test_reset();
        test_stream();
        test_hold();
        test_redirect();
        test_wrap();
        test_stall_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
